// File: rtl/spi_fwm_pkg.sv
// Shared constants for the SPI firmware-memory SRAM arbiter: requester indices and default
// SRAM geometry.
package spi_fwm_pkg;

  localparam int unsigned ReqHost   = 0;
  localparam int unsigned ReqRxf    = 1;
  localparam int unsigned ReqTxf    = 2;
  localparam int unsigned NumReqDef = 3;
  localparam int unsigned SramAwDef = 11;
  localparam int unsigned SramDwDef = 32;

  // Index width that stays legal for a single requester or a single-entry queue.
  function automatic int unsigned idx_w(int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/spi_fwm_sram_arb_if.sv
// Requester and SRAM bus bundle for spi_fwm_sram_arb; slave is the arbiter side, master is the
// environment (requesters plus SRAM).
interface spi_fwm_sram_arb_if import spi_fwm_pkg::*; #(
  parameter int unsigned NumReq = NumReqDef,
  parameter int unsigned SramAw = SramAwDef,
  parameter int unsigned SramDw = SramDwDef
) ();

  logic [NumReq-1:0]        req_i;
  logic [NumReq-1:0]        write_i;
  logic [NumReq*SramAw-1:0] addr_i;
  logic [NumReq*SramDw-1:0] wdata_i;
  logic [NumReq-1:0]        gnt_o;
  logic [NumReq-1:0]        rvalid_o;
  logic [SramDw-1:0]        rdata_o;
  logic [1:0]               rerror_o;

  logic                     sram_req_o;
  logic                     sram_write_o;
  logic [SramAw-1:0]        sram_addr_o;
  logic [SramDw-1:0]        sram_wdata_o;
  logic                     sram_gnt_i;
  logic                     sram_rvalid_i;
  logic [SramDw-1:0]        sram_rdata_i;
  logic [1:0]               sram_error_i;

  modport slave (
    input  req_i, write_i, addr_i, wdata_i,
    input  sram_gnt_i, sram_rvalid_i, sram_rdata_i, sram_error_i,
    output gnt_o, rvalid_o, rdata_o, rerror_o,
    output sram_req_o, sram_write_o, sram_addr_o, sram_wdata_o
  );

  modport master (
    output req_i, write_i, addr_i, wdata_i,
    output sram_gnt_i, sram_rvalid_i, sram_rdata_i, sram_error_i,
    input  gnt_o, rvalid_o, rdata_o, rerror_o,
    input  sram_req_o, sram_write_o, sram_addr_o, sram_wdata_o
  );

endinterface

// File: rtl/spi_fwm_arb_idq.sv
// In-order read-ID tracker: a small FIFO of requester indices, one entry per outstanding read.
module spi_fwm_arb_idq #(
  parameter int unsigned Width = 2,
  parameter int unsigned Depth = 2
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             i_push,
  input  logic [Width-1:0] i_data,
  input  logic             i_pop,
  output logic             o_full,
  output logic             o_empty,
  output logic [Width-1:0] o_head
);

  localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1;
  localparam int unsigned CntW = $clog2(Depth + 1);

  logic [Width-1:0] r_mem [Depth];
  logic [PtrW-1:0]  r_wptr;
  logic [PtrW-1:0]  r_rptr;
  logic [CntW-1:0]  r_cnt;
  logic             w_do_push;
  logic             w_do_pop;

  assign o_full    = (r_cnt == CntW'(Depth));
  assign o_empty   = (r_cnt == '0);
  assign o_head    = r_mem[r_rptr];
  assign w_do_push = i_push && !o_full;
  assign w_do_pop  = i_pop && !o_empty;

  function automatic logic [PtrW-1:0] ptr_inc(logic [PtrW-1:0] p);
    return (p == PtrW'(Depth - 1)) ? '0 : p + 1'b1;
  endfunction

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_wptr <= '0;
      r_rptr <= '0;
      r_cnt  <= '0;
    end else begin
      if (w_do_push) begin
        r_mem[r_wptr] <= i_data;
        r_wptr        <= ptr_inc(r_wptr);
      end
      if (w_do_pop) begin
        r_rptr <= ptr_inc(r_rptr);
      end
      case ({w_do_push, w_do_pop})
        2'b10:   r_cnt <= r_cnt + 1'b1;
        2'b01:   r_cnt <= r_cnt - 1'b1;
        default: r_cnt <= r_cnt;
      endcase
    end
  end

endmodule

// File: rtl/spi_fwm_sram_arb.sv
// Arbitrates host / rx-fifo / tx-fifo accesses onto one SRAM port and routes read responses back
// in order. Define SPI_FWM_ARB_RR_EN for round-robin; default is fixed priority (lowest wins).
module spi_fwm_sram_arb import spi_fwm_pkg::*; #(
  parameter int unsigned NumReq = NumReqDef,
  parameter int unsigned SramAw = SramAwDef,
  parameter int unsigned SramDw = SramDwDef,
  parameter int unsigned MaxOut = 2
) (
  input  logic                clk_i,
  input  logic                rst_i,
  spi_fwm_sram_arb_if.slave   bus,
  output logic                unexp_rvalid_o
);

  localparam int unsigned IdW = idx_w(NumReq);

  logic [IdW-1:0] w_win;
  logic           w_any;
  logic           w_full;
  logic           w_empty;
  logic [IdW-1:0] w_head;
  logic           w_sram_req;
  logic           w_accept;
  logic           w_push;
  logic           w_pop;
  logic           r_unexp;

`ifdef SPI_FWM_ARB_RR_EN
  // r_ptr holds where the next search starts: one past the last accepted index.
  logic [IdW-1:0] r_ptr;

  always_comb begin
    w_win = '0;
    w_any = 1'b0;
    for (int unsigned k = 0; k < NumReq; k++) begin
      if (!w_any && bus.req_i[(32'(r_ptr) + k) % NumReq]) begin
        w_any = 1'b1;
        w_win = IdW'((32'(r_ptr) + k) % NumReq);
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_ptr <= '0;
    end else if (w_accept) begin
      r_ptr <= (w_win == IdW'(NumReq - 1)) ? '0 : w_win + 1'b1;
    end
  end
`else
  always_comb begin
    w_win = '0;
    w_any = 1'b0;
    for (int unsigned k = 0; k < NumReq; k++) begin
      if (!w_any && bus.req_i[k]) begin
        w_any = 1'b1;
        w_win = IdW'(k);
      end
    end
  end
`endif

  assign w_sram_req = w_any && !w_full && !rst_i;
  assign w_accept   = w_sram_req && bus.sram_gnt_i;
  assign w_push     = w_accept && !bus.write_i[w_win];
  assign w_pop      = bus.sram_rvalid_i && !w_empty && !rst_i;

  assign bus.sram_req_o   = w_sram_req;
  assign bus.sram_write_o = w_any ? bus.write_i[w_win] : 1'b0;
  assign bus.sram_addr_o  = w_any ? bus.addr_i[32'(w_win) * SramAw +: SramAw] : '0;
  assign bus.sram_wdata_o = w_any ? bus.wdata_i[32'(w_win) * SramDw +: SramDw] : '0;
  assign bus.rdata_o      = bus.sram_rdata_i;
  assign bus.rerror_o     = bus.sram_error_i;

  always_comb begin
    bus.gnt_o    = '0;
    bus.rvalid_o = '0;
    for (int unsigned k = 0; k < NumReq; k++) begin
      bus.gnt_o[k]    = w_accept && (w_win == IdW'(k));
      bus.rvalid_o[k] = w_pop && (w_head == IdW'(k));
    end
  end

  spi_fwm_arb_idq #(
    .Width (IdW),
    .Depth (MaxOut)
  ) u_idq (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .i_push  (w_push),
    .i_data  (w_win),
    .i_pop   (w_pop),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_head  (w_head)
  );

  // A response with nothing outstanding (including one orphaned by reset) is flagged until reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_unexp <= 1'b0;
    end else if (bus.sram_rvalid_i && w_empty) begin
      r_unexp <= 1'b1;
    end
  end

  assign unexp_rvalid_o = r_unexp;

endmodule

// File: tb/tb_spi_fwm_sram_arb.sv
// Directed, table-driven bench for spi_fwm_sram_arb (default parameters, either arbitration mode).
module tb_spi_fwm_sram_arb;

  logic clk_i = 1'b0;
  logic rst_i;
  logic unexp_rvalid_o;

  spi_fwm_sram_arb_if #(.NumReq(3), .SramAw(11), .SramDw(32)) bus ();

  spi_fwm_sram_arb #(
    .NumReq (3),
    .SramAw (11),
    .SramDw (32),
    .MaxOut (2)
  ) dut (
    .clk_i          (clk_i),
    .rst_i          (rst_i),
    .bus            (bus),
    .unexp_rvalid_o (unexp_rvalid_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct packed {
    logic        rst;
    logic [2:0]  req;
    logic [2:0]  wr;
    logic        sgnt;
    logic        srv;
    logic [31:0] srd;
    logic [1:0]  serr;
    logic        e_sreq;
    logic        e_swr;
    logic [10:0] e_saddr;
    logic [31:0] e_wd;
    logic [2:0]  e_gnt;
    logic [2:0]  e_rv;
    logic        e_unexp;
  } vec_t;

  vec_t vq[$];
  int   n_chk = 0;
  int   n_err = 0;
  int   row   = 0;

  function automatic vec_t mk(logic rst, logic [2:0] req, logic [2:0] wr, logic sgnt, logic srv,
                              logic [31:0] srd, logic [1:0] serr, logic e_sreq, logic e_swr,
                              logic [10:0] e_saddr, logic [31:0] e_wd, logic [2:0] e_gnt,
                              logic [2:0] e_rv, logic e_unexp);
    vec_t v;
    v = '{rst, req, wr, sgnt, srv, srd, serr, e_sreq, e_swr, e_saddr, e_wd, e_gnt, e_rv, e_unexp};
    return v;
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s step %0d: got %h expected %h", name, row, act, exp);
    end
  endtask

  task automatic drive(logic rst, logic [2:0] req, logic [2:0] wr, logic sgnt, logic srv,
                       logic [31:0] srd, logic [1:0] serr);
    @(negedge clk_i);
    rst_i             = rst;
    bus.req_i         = req;
    bus.write_i       = wr;
    bus.sram_gnt_i    = sgnt;
    bus.sram_rvalid_i = srv;
    bus.sram_rdata_i  = srd;
    bus.sram_error_i  = serr;
    #2;
  endtask

  initial begin
    vec_t v;
    rst_i             = 1'b1;
    bus.req_i         = '0;
    bus.write_i       = '0;
    bus.addr_i        = {11'h123, 11'h7FF, 11'h010};
    bus.wdata_i       = {32'hDEADBEEF, 32'h12345678, 32'h0000_0000};
    bus.sram_gnt_i    = 1'b0;
    bus.sram_rvalid_i = 1'b0;
    bus.sram_rdata_i  = '0;
    bus.sram_error_i  = '0;

    // Reset with all requesting: nothing granted, payload still shows the winner.
    vq.push_back(mk(1, 3'b111, 0, 1, 0, 0, 0, 0, 0, 11'h010, 32'h0, 0, 0, 0));
    vq.push_back(mk(0, 3'b000, 0, 0, 0, 0, 0, 0, 0, 11'h000, 32'h0, 0, 0, 0));
    // Host read, response one cycle later.
    vq.push_back(mk(0, 3'b001, 0, 1, 0, 0, 0, 1, 0, 11'h010, 32'h0, 3'b001, 0, 0));
    vq.push_back(mk(0, 3'b000, 0, 0, 1, 32'hA5A5A5A5, 0, 0, 0, 0, 32'h0, 0, 3'b001, 0));
    // Rx write (no push), tx read, response routed to tx with error passthrough.
    vq.push_back(mk(0, 3'b010, 3'b010, 1, 0, 0, 0, 1, 1, 11'h7FF, 32'h12345678, 3'b010, 0, 0));
    vq.push_back(mk(0, 3'b100, 0, 1, 0, 0, 0, 1, 0, 11'h123, 32'hDEADBEEF, 3'b100, 0, 0));
    vq.push_back(mk(0, 3'b000, 0, 0, 1, 32'h11112222, 2'b10, 0, 0, 0, 32'h0, 0, 3'b100, 0));
    // Fill the tracker, then stall until a response frees a slot.
    vq.push_back(mk(0, 3'b001, 0, 1, 0, 0, 0, 1, 0, 11'h010, 32'h0, 3'b001, 0, 0));
    vq.push_back(mk(0, 3'b001, 0, 1, 0, 0, 0, 1, 0, 11'h010, 32'h0, 3'b001, 0, 0));
    vq.push_back(mk(0, 3'b100, 0, 1, 0, 0, 0, 0, 0, 11'h123, 32'hDEADBEEF, 0, 0, 0));
    vq.push_back(mk(0, 3'b100, 0, 1, 0, 0, 0, 0, 0, 11'h123, 32'hDEADBEEF, 0, 0, 0));
    vq.push_back(mk(0, 3'b100, 0, 1, 1, 32'h1, 0, 0, 0, 11'h123, 32'hDEADBEEF, 0, 3'b001, 0));
    vq.push_back(mk(0, 3'b100, 0, 1, 0, 0, 0, 1, 0, 11'h123, 32'hDEADBEEF, 3'b100, 0, 0));
    vq.push_back(mk(0, 3'b000, 0, 0, 1, 32'h2, 0, 0, 0, 0, 32'h0, 0, 3'b001, 0));
    vq.push_back(mk(0, 3'b000, 0, 0, 1, 32'h3, 1, 0, 0, 0, 32'h0, 0, 3'b100, 0));
    // Unexpected response: flag appears next cycle, sticks, clears after reset.
    vq.push_back(mk(0, 3'b000, 0, 0, 1, 32'h4, 0, 0, 0, 0, 32'h0, 0, 0, 0));
    vq.push_back(mk(0, 3'b000, 0, 0, 0, 0, 0, 0, 0, 0, 32'h0, 0, 0, 1));
    vq.push_back(mk(0, 3'b000, 0, 0, 0, 0, 0, 0, 0, 0, 32'h0, 0, 0, 1));
    vq.push_back(mk(1, 3'b000, 0, 0, 0, 0, 0, 0, 0, 0, 32'h0, 0, 0, 1));
    vq.push_back(mk(0, 3'b000, 0, 0, 0, 0, 0, 0, 0, 0, 32'h0, 0, 0, 0));
    // All three requesting for six cycles, responses returned back to back.
`ifdef SPI_FWM_ARB_RR_EN
    vq.push_back(mk(0, 3'b111, 0, 1, 0, 0, 0, 1, 0, 11'h010, 32'h0, 3'b001, 0, 0));
    vq.push_back(mk(0, 3'b111, 0, 1, 1, 0, 0, 1, 0, 11'h7FF, 32'h12345678, 3'b010, 3'b001, 0));
    vq.push_back(mk(0, 3'b111, 0, 1, 1, 0, 0, 1, 0, 11'h123, 32'hDEADBEEF, 3'b100, 3'b010, 0));
    vq.push_back(mk(0, 3'b111, 0, 1, 1, 0, 0, 1, 0, 11'h010, 32'h0, 3'b001, 3'b100, 0));
    vq.push_back(mk(0, 3'b111, 0, 1, 1, 0, 0, 1, 0, 11'h7FF, 32'h12345678, 3'b010, 3'b001, 0));
    vq.push_back(mk(0, 3'b111, 0, 1, 1, 0, 0, 1, 0, 11'h123, 32'hDEADBEEF, 3'b100, 3'b010, 0));
    vq.push_back(mk(0, 3'b000, 0, 0, 1, 0, 0, 0, 0, 0, 32'h0, 0, 3'b100, 0));
`else
    for (int i = 0; i < 6; i++) begin
      vq.push_back(mk(0, 3'b111, 0, 1, (i > 0), 0, 0, 1, 0, 11'h010, 32'h0, 3'b001,
                      (i > 0) ? 3'b001 : 3'b000, 0));
    end
    vq.push_back(mk(0, 3'b000, 0, 0, 1, 0, 0, 0, 0, 0, 32'h0, 0, 3'b001, 0));
`endif
    // Reset with a read outstanding: the late response is unexpected.
    vq.push_back(mk(0, 3'b001, 0, 1, 0, 0, 0, 1, 0, 11'h010, 32'h0, 3'b001, 0, 0));
    vq.push_back(mk(1, 3'b000, 0, 0, 0, 0, 0, 0, 0, 0, 32'h0, 0, 0, 0));
    vq.push_back(mk(0, 3'b000, 0, 0, 1, 32'h5, 0, 0, 0, 0, 32'h0, 0, 0, 0));
    vq.push_back(mk(0, 3'b000, 0, 0, 0, 0, 0, 0, 0, 0, 32'h0, 0, 0, 1));
    vq.push_back(mk(0, 3'b010, 0, 0, 0, 0, 0, 1, 0, 11'h7FF, 32'h12345678, 0, 0, 1));

    foreach (vq[i]) begin
      v   = vq[i];
      row = i;
      drive(v.rst, v.req, v.wr, v.sgnt, v.srv, v.srd, v.serr);
      chk("gnt_o", 32'(bus.gnt_o), 32'(v.e_gnt));
      chk("rvalid_o", 32'(bus.rvalid_o), 32'(v.e_rv));
      chk("sram_req_o", 32'(bus.sram_req_o), 32'(v.e_sreq));
      chk("sram_write_o", 32'(bus.sram_write_o), 32'(v.e_swr));
      chk("sram_addr_o", 32'(bus.sram_addr_o), 32'(v.e_saddr));
      chk("sram_wdata_o", bus.sram_wdata_o, v.e_wd);
      chk("rdata_o", bus.rdata_o, v.srd);
      chk("rerror_o", 32'(bus.rerror_o), 32'(v.serr));
      chk("unexp_rvalid_o", 32'(unexp_rvalid_o), 32'(v.e_unexp));
    end

    // Ungranted request withdrawn: no tracker entry, so a later response is unexpected.
    row = 1000;
    drive(1, 3'b000, 0, 0, 0, 0, 0);
    drive(0, 3'b010, 0, 0, 0, 0, 0);
    chk("drop_gnt0", 32'(bus.gnt_o), 32'h0);
    chk("drop_sreq0", 32'(bus.sram_req_o), 32'h1);
    drive(0, 3'b010, 0, 0, 0, 0, 0);
    chk("drop_gnt1", 32'(bus.gnt_o), 32'h0);
    drive(0, 3'b000, 0, 0, 1, 32'h6, 0);
    chk("drop_rvalid", 32'(bus.rvalid_o), 32'h0);
    chk("drop_unexp_pre", 32'(unexp_rvalid_o), 32'h0);
    for (int i = 0; i < 4; i++) begin
      drive(0, 3'b000, 0, 0, 0, 0, 0);
      chk("drop_unexp_sticky", 32'(unexp_rvalid_o), 32'h1);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1);
  end

endmodule
